// File: rtl/fanin_link_pkg.sv
// fanin_link_pkg: token types, default sizes and FSM states shared by fanin_link and its arbiter.
package fanin_link_pkg;
  localparam int WIDTH_DATA = 32;
  localparam int NUM_LINK_DEF = 4;
  localparam int NUM_CHANNEL_DEF = 1;
  typedef struct packed {
    logic v;
    logic a;
    logic r;
    logic c;
    logic [WIDTH_DATA-1:0] d;
  } FTk_t;
  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;
  typedef FTk_t ftk_link_t [NUM_LINK_DEF];
  typedef BTk_t btk_link_t [NUM_LINK_DEF];
  typedef enum logic {FANIN_IDLE, FANIN_BUSY} fanin_st_t;
  localparam BTk_t BTK_NACK = '{n: 1'b1, t: 1'b0, v: 1'b0, c: 1'b0};
endpackage

// File: rtl/fanin_arbiter.sv
// fanin_arbiter: round-robin picker; the pointer records the last granted index.
module fanin_arbiter import fanin_link_pkg::*; #(
  parameter int N = NUM_LINK_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         upd,
  output logic [N-1:0] gnt
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] ptr;
  // Scan from farthest to nearest so the nearest requester past ptr wins.
  always_comb begin
    int k;
    k = 0;
    gnt = '0;
    for (int i = N; i >= 1; i--) begin
      k = int'(ptr) + i;
      k = k >= N ? k - N : k;
      if (req[k[PW-1:0]]) begin
        gnt = '0;
        gnt[k[PW-1:0]] = 1'b1;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) ptr <= '0;
    else if (upd)
      for (int i = 0; i < N; i++)
        if (gnt[i]) ptr <= PW'(i);
  end
endmodule

// File: rtl/fanin_link.sv
// fanin_link: merges NUM_LINK token streams per channel with message-granular round-robin.
// Define FANIN_LINK_TIMEOUT_EN to drop grants held idle for TIMEOUT cycles.
module fanin_link import fanin_link_pkg::*; #(
  parameter int NUM_LINK = NUM_LINK_DEF,
  parameter int NUM_CHANNEL = NUM_CHANNEL_DEF
`ifdef FANIN_LINK_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  FTk_t                I_FTk [NUM_LINK][NUM_CHANNEL],
  output BTk_t                O_BTk [NUM_LINK][NUM_CHANNEL],
  output FTk_t                O_FTk [NUM_CHANNEL],
  input  BTk_t                I_BTk [NUM_CHANNEL],
  output logic [NUM_LINK-1:0] O_Grt [NUM_CHANNEL]
);
  for (genvar c = 0; c < NUM_CHANNEL; c++) begin : g_ch
    fanin_st_t st;
    logic [NUM_LINK-1:0] req, pick, grt;
    FTk_t fwd, ftk_q;
    BTk_t btk_g;
    logic acc, rel, tmo;
    always_comb begin
      fwd = '0;
      for (int i = 0; i < NUM_LINK; i++) begin
        req[i] = I_FTk[i][c].v & I_FTk[i][c].a;
        if (grt[i]) fwd = I_FTk[i][c];
      end
    end
    assign acc = st == FANIN_BUSY && fwd.v && !I_BTk[c].n;
    assign rel = (acc && (fwd.r || I_BTk[c].t)) || tmo;
    fanin_arbiter #(.N(NUM_LINK)) u_arb (
      .clock(clock),
      .reset(reset),
      .req  (req),
      .upd  (st == FANIN_IDLE && |req),
      .gnt  (pick)
    );
    always_ff @(posedge clock) begin
      if (!reset) begin
        st <= FANIN_IDLE;
        grt <= '0;
        ftk_q <= '0;
      end else begin
        if (!I_BTk[c].n) ftk_q <= acc ? fwd : '0;
        if (st == FANIN_IDLE && |req) begin
          st <= FANIN_BUSY;
          grt <= pick;
        end else if (st == FANIN_BUSY && rel) begin
          st <= FANIN_IDLE;
          grt <= '0;
        end
      end
    end
`ifdef FANIN_LINK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] cnt;
    assign tmo = st == FANIN_BUSY && cnt == TW'(TIMEOUT);
    always_ff @(posedge clock) begin
      if (!reset) cnt <= '0;
      else cnt <= (st != FANIN_BUSY || fwd.v || tmo) ? '0 : cnt + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif
    always_comb begin
      btk_g = I_BTk[c];
      btk_g.t = I_BTk[c].t | tmo;
    end
    for (genvar l = 0; l < NUM_LINK; l++) begin : g_lk
      assign O_BTk[l][c] = grt[l] ? btk_g : (I_FTk[l][c].v ? BTK_NACK : BTk_t'('0));
    end
    assign O_FTk[c] = ftk_q;
    assign O_Grt[c] = grt;
  end
endmodule
